// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard / stall controller for a 5-stage in-order pipeline.
//   Decides, every cycle, which pipeline latches and the PC may advance and
//   which latches must load a bubble, based on memory wait, load-use hazards,
//   branch/jump redirects, instruction fetch misses and halt.
//
//   Priority (highest first): HALT > mem_busy > pc_redirect > load_use > !ihit
//
//   Ports
//     CLK                      clock, rising edge
//     nRST                     asynchronous active-low reset
//     ihit, dhit               instruction fetch / data access complete
//     exmem_dREN, exmem_dWEN   load / store in MEM stage
//     idex_dREN, idex_rt       load in EX and its destination register
//     ifid_rs, ifid_rt         source registers of the instruction in ID
//     pc_redirect              taken branch / jump resolved in EX
//     wb_halt                  halt instruction reached WB
//     pc_en .. memwb_en        PC update and pipeline latch enables
//     ifid_flush .. exmem_flush  load a bubble into that latch on next edge
//     halted                   sticky halt indication (cleared by reset only)
//
//   Optional build macro HAZARD_STATS_EN adds:
//     stall_cnt [31:0]         cycles with pc_en=0 outside HALT (saturating)
//     flush_cnt [15:0]         cycles with any flush asserted (saturating)
// -----------------------------------------------------------------------------
module hazard_ctrl (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       ihit,
    input  logic       dhit,
    input  logic       exmem_dREN,
    input  logic       exmem_dWEN,
    input  logic       idex_dREN,
    input  logic [4:0] idex_rt,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    input  logic       pc_redirect,
    input  logic       wb_halt,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       idex_en,
    output logic       exmem_en,
    output logic       memwb_en,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exmem_flush,
    output logic       halted
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        MEMWAIT = 2'd2,
        HALT    = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic mem_busy;
    logic load_use;

    assign mem_busy = (exmem_dREN | exmem_dWEN) & ~dhit;

    // Register 0 is hardwired to zero, so a load targeting it never
    // creates a real dependency.
    assign load_use = idex_dREN & (idex_rt != 5'd0) &
                      ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        next_state  = RUN;

        if (state == HALT) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            next_state = HALT;
        end else if (mem_busy) begin
            // Whole pipeline freezes until the data access completes.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            next_state = MEMWAIT;
        end else if (pc_redirect) begin
            // Wrong-path instructions in IF/ID and ID/EX are squashed; this
            // also removes the consumer of any pending load-use hazard.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use && (state != LDSTALL)) begin
            // Hold PC and IF/ID, insert one bubble into EX. In LDSTALL the
            // load has already moved on, so the hazard is not re-checked.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            next_state = LDSTALL;
        end else if (!ihit) begin
            // Fetch miss: hold PC, feed a bubble into ID, drain the rest.
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end

        if (wb_halt) begin
            next_state = HALT;
        end
    end

    assign halted = (state == HALT);

`ifdef HAZARD_STATS_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (!pc_en && (state != HALT)) begin
                stall_cnt <= sat_inc32(stall_cnt);
            end
            if (ifid_flush | idex_flush | exmem_flush) begin
                flush_cnt <= sat_inc16(flush_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       ihit, dhit, exmem_dREN, exmem_dWEN, idex_dREN;
    logic [4:0] idex_rt, ifid_rs, ifid_rt;
    logic       pc_redirect, wb_halt;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, exmem_flush, halted;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    hazard_ctrl dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
        .idex_dREN(idex_dREN), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .pc_redirect(pc_redirect), .wb_halt(wb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .halted(halted)
`ifdef HAZARD_STATS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode of the controller as a plain integer.
    localparam int M_RUN = 0, M_LDSTALL = 1, M_MEMWAIT = 2, M_HALT = 3;
    // What the controller is doing this cycle.
    localparam int K_HALT = 0, K_MEM = 1, K_REDIR = 2, K_LU = 3, K_FETCH = 4, K_NONE = 5;

    int          m_state = M_RUN;
    int          halt_age = 0;
    logic [31:0] stall_exp = 0;
    logic [15:0] flush_exp = 0;

    function automatic int kind_now();
        bit mb, lu;
        mb = (exmem_dREN || exmem_dWEN) && !dhit;
        lu = idex_dREN && (idex_rt != 0) && (idex_rt == ifid_rs || idex_rt == ifid_rt);
        if (m_state == M_HALT) return K_HALT;
        if (mb) return K_MEM;
        if (pc_redirect) return K_REDIR;
        if (lu && m_state != M_LDSTALL) return K_LU;
        if (!ihit) return K_FETCH;
        return K_NONE;
    endfunction

    // {pc_en,ifid_en,idex_en,exmem_en,memwb_en,ifid_fl,idex_fl,exmem_fl,halted}
    function automatic logic [8:0] exp_vec(input int k);
        case (k)
            K_HALT:  return 9'b00000_000_1;
            K_MEM:   return 9'b00000_000_0;
            K_REDIR: return 9'b11111_110_0;
            K_LU:    return 9'b00111_010_0;
            K_FETCH: return 9'b01111_100_0;
            default: return 9'b11111_000_0;
        endcase
    endfunction

    task automatic compare_now(input string tag);
        logic [8:0] obs, exp;
        obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halted};
        exp = exp_vec(kind_now());
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ih, input logic dh, input logic dr, input logic dw,
                         input logic ld, input logic [4:0] rt, input logic [4:0] rs,
                         input logic [4:0] rt2, input logic pr, input logic wh);
        ihit = ih; dhit = dh; exmem_dREN = dr; exmem_dWEN = dw;
        idex_dREN = ld; idex_rt = rt; ifid_rs = rs; ifid_rt = rt2;
        pc_redirect = pr; wb_halt = wh;
    endtask

    task automatic quiet();
        drive(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    // Called 1 time unit after a rising edge: check, then advance one cycle.
    task automatic step(input string tag);
        int k, nxt;
        logic [8:0] e;
        #3;
        compare_now(tag);
        k = kind_now();
        e = exp_vec(k);
        if (wb_halt || k == K_HALT) nxt = M_HALT;
        else if (k == K_MEM) nxt = M_MEMWAIT;
        else if (k == K_LU) nxt = M_LDSTALL;
        else nxt = M_RUN;
        @(posedge CLK);
        if (!nRST) begin
            m_state = M_RUN;
            stall_exp = 0;
            flush_exp = 0;
        end else begin
            if (!e[8] && k != K_HALT && stall_exp != 32'hFFFF_FFFF) stall_exp++;
            if ((|e[3:1]) && flush_exp != 16'hFFFF) flush_exp++;
            m_state = nxt;
        end
        halt_age = (m_state == M_HALT) ? halt_age + 1 : 0;
        #1;
    endtask

    task automatic async_reset(input string tag);
        nRST = 1'b0;
        #1;
        m_state = M_RUN;
        halt_age = 0;
        stall_exp = 0;
        flush_exp = 0;
        compare_now(tag);
        n_cmp++;
        assert (halted === 1'b0) else begin
            n_bad++;
            $error("FAIL %s_halted observed=%b expected=0", tag, halted);
        end
    endtask

    initial begin
        nRST = 1'b0;
        quiet();
        @(posedge CLK); #1;

        // Outputs during reset follow the normal run equations.
        step("reset_idle");
        ihit = 0;
        step("reset_fetch_miss");
        quiet();
        nRST = 1'b1;
        step("idle");

        // Load-use on rs: one stall cycle, then run even though hazard persists.
        drive(1, 1, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0);
        step("lu_stall");
        step("lu_release");
        quiet();
        step("after_lu");

        // Load to r0 never stalls.
        drive(1, 1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0);
        step("lu_r0");

        // Load-use on rt.
        drive(1, 1, 0, 0, 1, 5'd7, 5'd1, 5'd7, 0, 0);
        step("lu_rt_stall");
        quiet();
        step("lu_rt_done");

        // Data access waits three cycles then completes.
        drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("memwait_1");
        step("memwait_2");
        step("memwait_3");
        dhit = 1;
        step("memwait_done");
        quiet();
        step("memwait_run");

        // Store stalls too, and overrides a redirect.
        drive(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 1, 0);
        step("store_wait_redir");
        quiet();
        step("store_done");

        // Redirect beats load-use.
        drive(1, 1, 0, 0, 1, 5'd3, 5'd3, 5'd0, 1, 0);
        step("redir_over_lu");
        pc_redirect = 0;
        step("lu_after_redir");
        quiet();
        step("lu_after_redir_done");

        // Fetch miss.
        ihit = 0;
        step("fetch_miss");
        quiet();

        // Async reset in the middle of LDSTALL re-evaluates load_use in RUN.
        drive(1, 1, 0, 0, 1, 5'd9, 5'd9, 5'd0, 0, 0);
        step("lu_before_rst");
        async_reset("rst_mid_ldstall");
        step("rst_ldstall_hold");
        nRST = 1'b1;
        quiet();
        step("rst_ldstall_release");

        // Async reset in the middle of MEMWAIT.
        drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("mw_before_rst");
        dhit = 1;
        async_reset("rst_mid_memwait");
        nRST = 1'b1;
        quiet();
        step("rst_memwait_release");

        // Halt is sticky regardless of inputs, cleared only by reset.
        wb_halt = 1;
        step("halt_pulse");
        wb_halt = 0;
        step("halt_1");
        drive(0, 0, 1, 1, 1, 5'd2, 5'd2, 5'd2, 1, 0);
        step("halt_2");
        step("halt_3");
        async_reset("rst_from_halt");
        nRST = 1'b1;
        quiet();
        step("halt_cleared");

        // Randomized run against the model.
        for (int i = 0; i < 500; i++) begin
            if (halt_age > 3) begin
                async_reset("rand_rst");
                quiet();
                step("rand_rst_hold");
                nRST = 1'b1;
            end
            drive($urandom_range(0, 99) < 85,
                  $urandom_range(0, 99) < 60,
                  $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 40,
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 2);
            step("rand");
        end

`ifdef HAZARD_STATS_EN
        n_cmp++;
        assert (stall_cnt === stall_exp) else begin
            n_bad++;
            $error("FAIL stall_cnt observed=%h expected=%h", stall_cnt, stall_exp);
        end
        n_cmp++;
        assert (flush_cnt === flush_exp) else begin
            n_bad++;
            $error("FAIL flush_cnt observed=%h expected=%h", flush_cnt, flush_exp);
        end
        // Saturation: preset near the top, keep stalling.
        async_reset("stats_rst");
        nRST = 1'b1;
        quiet();
        #2;
        force dut.stall_cnt = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cnt;
        stall_exp = 32'hFFFF_FFFD;
        ihit = 0;
        for (int i = 0; i < 5; i++) step("stats_stall");
        n_cmp++;
        assert (stall_cnt === 32'hFFFF_FFFF) else begin
            n_bad++;
            $error("FAIL stall_cnt_sat observed=%h expected=ffffffff", stall_cnt);
        end
        quiet();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
